// File: rtl/voice_mixer.sv
// voice_mixer: snapshots 16 enveloped voices on each sample tick, sums them
// one voice per clock in a 20-bit accumulator, scales by 2^-GAIN_SHIFT,
// saturates (or truncates) to 16 bits and emits one registered mono sample.
module voice_mixer #(
   parameter int GAIN_SHIFT = 2,     // 0..4
   parameter bit SAT_EN     = 1'b1   // 1: saturate, 0: keep low 16 bits
) (
   input  logic               CLOCK12M,
   input  logic               RESET,
   input  logic               sample_tick,
   input  logic signed [15:0] wave0ADSR,
   input  logic signed [15:0] wave1ADSR,
   input  logic signed [15:0] wave2ADSR,
   input  logic signed [15:0] wave3ADSR,
   input  logic signed [15:0] wave4ADSR,
   input  logic signed [15:0] wave5ADSR,
   input  logic signed [15:0] wave6ADSR,
   input  logic signed [15:0] wave7ADSR,
   input  logic signed [15:0] wave8ADSR,
   input  logic signed [15:0] wave9ADSR,
   input  logic signed [15:0] wave10ADSR,
   input  logic signed [15:0] wave11ADSR,
   input  logic signed [15:0] wave12ADSR,
   input  logic signed [15:0] wave13ADSR,
   input  logic signed [15:0] wave14ADSR,
   input  logic signed [15:0] wave15ADSR,
   input  logic        [15:0] voice_en,
   input  logic               clip_clr,
   output logic signed [15:0] sample_out,
   output logic               sample_valid,
   output logic               busy,
   output logic               clip,
   output logic               overrun
);

   typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

   state_t             state_q, state_d;
   logic        [3:0]  idx_q, idx_d;
   logic signed [19:0] acc_q, acc_d;
   logic signed [15:0] snap_q [16];
   logic signed [15:0] snap_d [16];
   logic signed [15:0] out_q, out_d;
   logic               valid_q, valid_d;
   logic               clip_q, clip_d;
   logic               ovr_q, ovr_d;

   logic signed [15:0] wave_in [16];
   logic signed [19:0] scaled;
   logic signed [15:0] cur_voice;

   // True when the scaled sum does not fit a 16-bit signed sample.
   function automatic logic out_of_range(input logic signed [19:0] v);
      return (v > 20'sd32767) || (v < -20'sd32768);
   endfunction

   // Reduce the scaled sum to 16 bits: clamp when SAT_EN, else wrap.
   function automatic logic signed [15:0] limit16(input logic signed [19:0] v);
      logic signed [15:0] res;
      res = v[15:0];
      if (SAT_EN) begin
         if (v > 20'sd32767)
            res = 16'sh7FFF;
         else if (v < -20'sd32768)
            res = 16'sh8000;
      end
      return res;
   endfunction

   assign wave_in[0]  = wave0ADSR;
   assign wave_in[1]  = wave1ADSR;
   assign wave_in[2]  = wave2ADSR;
   assign wave_in[3]  = wave3ADSR;
   assign wave_in[4]  = wave4ADSR;
   assign wave_in[5]  = wave5ADSR;
   assign wave_in[6]  = wave6ADSR;
   assign wave_in[7]  = wave7ADSR;
   assign wave_in[8]  = wave8ADSR;
   assign wave_in[9]  = wave9ADSR;
   assign wave_in[10] = wave10ADSR;
   assign wave_in[11] = wave11ADSR;
   assign wave_in[12] = wave12ADSR;
   assign wave_in[13] = wave13ADSR;
   assign wave_in[14] = wave14ADSR;
   assign wave_in[15] = wave15ADSR;

   assign cur_voice = snap_q[idx_q];
   assign scaled    = acc_q >>> GAIN_SHIFT;

   // Next-state logic: snapshot on tick, accumulate one voice per cycle, scale.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      snap_d  = snap_q;
      out_d   = out_q;
      valid_d = 1'b0;
      clip_d  = clip_q;
      ovr_d   = ovr_q;

      // Clear first so a clip detected in the same cycle takes precedence.
      if (clip_clr)
         clip_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (sample_tick) begin
               for (int n = 0; n < 16; n++)
                  snap_d[n] = voice_en[n] ? wave_in[n] : 16'sd0;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_q + {{4{cur_voice[15]}}, cur_voice};
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15)
               state_d = SCALE;
         end
         SCALE: begin
            if (out_of_range(scaled))
               clip_d = 1'b1;
            out_d   = limit16(scaled);
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A tick that cannot start a new mix is dropped and flagged.
      if (sample_tick && (state_q != IDLE))
         ovr_d = 1'b1;
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge CLOCK12M or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         for (int n = 0; n < 16; n++)
            snap_q[n] <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         clip_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         snap_q  <= snap_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         clip_q  <= clip_d;
         ovr_q   <= ovr_d;
      end
   end

   assign sample_out   = out_q;
   assign sample_valid = valid_q;
   assign busy         = (state_q != IDLE);
   assign clip         = clip_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: three instances share the stimulus
// (GAIN_SHIFT=2 saturating, GAIN_SHIFT=0 saturating, GAIN_SHIFT=2 truncating).
module tb_voice_mixer;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               tick;
   logic signed [15:0] w [16];
   logic        [15:0] en;
   logic               cclr;

   logic signed [15:0] out_a, out_b, out_c;
   logic               vld_a, vld_b, vld_c;
   logic               busy_a, busy_b, busy_c;
   logic               clip_a, clip_b, clip_c;
   logic               ovr_a, ovr_b, ovr_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   voice_mixer #(.GAIN_SHIFT(2), .SAT_EN(1'b1)) dut_a (
      .CLOCK12M(clk), .RESET(rst_n), .sample_tick(tick),
      .wave0ADSR(w[0]), .wave1ADSR(w[1]), .wave2ADSR(w[2]), .wave3ADSR(w[3]),
      .wave4ADSR(w[4]), .wave5ADSR(w[5]), .wave6ADSR(w[6]), .wave7ADSR(w[7]),
      .wave8ADSR(w[8]), .wave9ADSR(w[9]), .wave10ADSR(w[10]), .wave11ADSR(w[11]),
      .wave12ADSR(w[12]), .wave13ADSR(w[13]), .wave14ADSR(w[14]), .wave15ADSR(w[15]),
      .voice_en(en), .clip_clr(cclr), .sample_out(out_a), .sample_valid(vld_a),
      .busy(busy_a), .clip(clip_a), .overrun(ovr_a));

   voice_mixer #(.GAIN_SHIFT(0), .SAT_EN(1'b1)) dut_b (
      .CLOCK12M(clk), .RESET(rst_n), .sample_tick(tick),
      .wave0ADSR(w[0]), .wave1ADSR(w[1]), .wave2ADSR(w[2]), .wave3ADSR(w[3]),
      .wave4ADSR(w[4]), .wave5ADSR(w[5]), .wave6ADSR(w[6]), .wave7ADSR(w[7]),
      .wave8ADSR(w[8]), .wave9ADSR(w[9]), .wave10ADSR(w[10]), .wave11ADSR(w[11]),
      .wave12ADSR(w[12]), .wave13ADSR(w[13]), .wave14ADSR(w[14]), .wave15ADSR(w[15]),
      .voice_en(en), .clip_clr(cclr), .sample_out(out_b), .sample_valid(vld_b),
      .busy(busy_b), .clip(clip_b), .overrun(ovr_b));

   voice_mixer #(.GAIN_SHIFT(2), .SAT_EN(1'b0)) dut_c (
      .CLOCK12M(clk), .RESET(rst_n), .sample_tick(tick),
      .wave0ADSR(w[0]), .wave1ADSR(w[1]), .wave2ADSR(w[2]), .wave3ADSR(w[3]),
      .wave4ADSR(w[4]), .wave5ADSR(w[5]), .wave6ADSR(w[6]), .wave7ADSR(w[7]),
      .wave8ADSR(w[8]), .wave9ADSR(w[9]), .wave10ADSR(w[10]), .wave11ADSR(w[11]),
      .wave12ADSR(w[12]), .wave13ADSR(w[13]), .wave14ADSR(w[14]), .wave15ADSR(w[15]),
      .voice_en(en), .clip_clr(cclr), .sample_out(out_c), .sample_valid(vld_c),
      .busy(busy_c), .clip(clip_c), .overrun(ovr_c));

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic signed [15:0] v);
      for (int i = 0; i < 16; i++) w[i] = v;
   endtask

   // Pulse a tick (edge 0), optionally scramble inputs during ACCUM, then
   // check that valid stays low until edge 17 and carries the expected results.
   task automatic run_mix(input string tag, input bit scramble,
                          input int ea, input int eb, input int ec);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk({tag, " busy_after_tick"}, busy_a, 1);
      if (scramble) begin
         set_all(16'sd12345);
         en = 16'hFFFF;
      end
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (vld_a || vld_b || vld_c) chk({tag, " early_valid"}, 1, 0);
      end
      chk({tag, " busy_edge16"}, busy_a, 1);
      cyc();
      chk({tag, " valid_a"}, vld_a, 1);
      chk({tag, " valid_b"}, vld_b, 1);
      chk({tag, " out_a"}, out_a, ea);
      chk({tag, " out_b"}, out_b, eb);
      chk({tag, " out_c"}, out_c, ec);
      chk({tag, " busy_done"}, busy_a, 0);
      cyc();
      chk({tag, " valid_pulse_len"}, vld_a, 0);
      chk({tag, " out_hold"}, out_a, ea);
   endtask

   initial begin
      rst_n = 1'b0;
      tick  = 1'b0;
      cclr  = 1'b0;
      en    = 16'hFFFF;
      set_all(16'sd0);
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (10) cyc();
      chk("idle out", out_a, 0);
      chk("idle valid", vld_a, 0);
      chk("idle busy", busy_a, 0);
      chk("idle clip", clip_a, 0);
      chk("idle overrun", ovr_a, 0);

      // 16 x 1000 = 16000
      set_all(16'sd1000);
      run_mix("sum1000", 1'b0, 4000, 16000, 4000);
      chk("sum1000 clip", clip_a, 0);

      // 16 x 32767 = 524272; >>2 = 131068 (0x1FFFC, low half = -4)
      set_all(16'sd32767);
      run_mix("posfull", 1'b0, 32767, 32767, -4);
      chk("posfull clip_a", clip_a, 1);
      chk("posfull clip_b", clip_b, 1);
      chk("posfull clip_c", clip_c, 1);

      // 16 x -32768 = -524288; >>2 = -131072 (low half = 0)
      set_all(-16'sd32768);
      run_mix("negfull", 1'b0, -32768, -32768, 0);
      chk("negfull clip", clip_a, 1);

      cclr = 1'b1;
      cyc();
      cclr = 1'b0;
      chk("clip_clr a", clip_a, 0);
      chk("clip_clr c", clip_c, 0);

      // Only voices 0 and 5: -20000 + 8000 = -12000; inputs scrambled mid-mix
      set_all(16'sd7000);
      w[0] = -16'sd20000;
      w[5] = 16'sd8000;
      en   = 16'h0021;
      run_mix("mask", 1'b1, -3000, -12000, -3000);
      chk("mask clip", clip_a, 0);
      chk("mask no_overrun", ovr_a, 0);

      // Second tick 5 cycles after the first is dropped and flags overrun
      set_all(16'sd1000);
      en   = 16'hFFFF;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (4) cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("ovr flag", ovr_a, 1);
      repeat (11) cyc();
      chk("ovr not_early", vld_a, 0);
      cyc();
      chk("ovr valid", vld_a, 1);
      chk("ovr out_a", out_a, 4000);
      chk("ovr out_b", out_b, 16000);
      cyc();
      chk("ovr no_restart", busy_a, 0);
      repeat (20) cyc();
      chk("ovr sticky", ovr_a, 1);

      // Reset at idx=8 aborts the mix
      set_all(16'sd2000);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (8) cyc();
      rst_n = 1'b0;
      #1;
      chk("abort busy", busy_a, 0);
      chk("abort out", out_a, 0);
      chk("abort overrun", ovr_a, 0);
      chk("abort valid", vld_a, 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (vld_a) chk("abort stray_valid", vld_a, 0);
      end
      chk("abort idle", busy_a, 0);

      // Fresh mix after abort: 4 x 1000 = 4000
      set_all(16'sd1000);
      en = 16'h000F;
      run_mix("fresh", 1'b0, 1000, 4000, 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
